// File: rtl/spi_master.sv
// Mode-0 SPI master: one WIDTH-bit full-duplex transfer per accepted start, sclk half-period CLK_DIV clk.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting in both directions; MSB-first otherwise.
module spi_master #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] txData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rxData,
    output logic             sclk,
    output logic             cs,
    output logic             mosi,
    input  logic             miso
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_HIGH, S_LOW, S_TRAIL, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             sclk_q, sclk_d;
    logic             cs_q, cs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             phase_end;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_insert;

    // mosi is taken straight from the shift register end, so clearing tx_q forces the line low.
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign mosi      = tx_q[0];
    assign tx_shift  = {1'b0, tx_q[WIDTH-1:1]};
    assign rx_insert = {miso, rx_q[WIDTH-1:1]};
`else
    assign mosi      = tx_q[WIDTH-1];
    assign tx_shift  = {tx_q[WIDTH-2:0], 1'b0};
    assign rx_insert = {rx_q[WIDTH-2:0], miso};
`endif

    assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != S_IDLE && state_q != S_DONE) begin
            div_d = phase_end ? '0 : div_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tx_d    = txData;
                    rx_d    = '0;
                    bit_d   = '0;
                    div_d   = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_LEAD;
                end
            end
            S_LEAD, S_LOW: begin
                if (phase_end) begin
                    sclk_d  = 1'b1;
                    rx_d    = rx_insert;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    sclk_d = 1'b0;
                    if (bit_q == BIT_W'(WIDTH - 1)) begin
                        state_d = S_TRAIL;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = tx_shift;
                        state_d = S_LOW;
                    end
                end
            end
            S_TRAIL: begin
                if (phase_end) begin
                    cs_d      = 1'b1;
                    tx_d      = '0;
                    rx_data_d = rx_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign rxData = rx_data_q;
    assign sclk   = sclk_q;
    assign cs     = cs_q;

endmodule
